// File: rtl/maxheap_pkg.sv
// Shared types and helpers for the max-heap priority queue (pop and sink sides).
// Holds the pop FSM state enum and the heap child-index helpers.
package maxheap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    OFFER,
    LAST,
    RDL,
    RDR,
    CMP
  } maxheap_pop_state_e;

  function automatic int unsigned heap_left(input int unsigned i);
    return 2 * i + 1;
  endfunction

  function automatic int unsigned heap_right(input int unsigned i);
    return 2 * i + 2;
  endfunction

endpackage

// File: rtl/maxheap_pop.sv
// Max-heap pop side: streams the root entry out on valid/ready, then sift-down over external RAM.
// Optional statistics ports (pop_total, sift_max) exist when MAXHEAP_POP_STATS_EN is defined.
module maxheap_pop
  import maxheap_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int PRIO_WIDTH = 32,
  parameter int TOT_SIZE   = 4,
  localparam int AW = (TOT_SIZE > 1) ? $clog2(TOT_SIZE) : 1,
  localparam int CW = $clog2(TOT_SIZE + 1),
  localparam int EW = PRIO_WIDTH + DATA_WIDTH
) (
  input  logic                  source_clk,
  input  logic                  reset,
  output logic                  source_valid,
  input  logic                  source_ready,
  output logic [DATA_WIDTH-1:0] source_data,
  output logic [PRIO_WIDTH-1:0] source_prio,
  input  logic [CW-1:0]         heap_count,
  output logic                  heap_dec,
  output logic                  pop_busy,
  output logic [AW-1:0]         mem_rd_addr,
  input  logic [EW-1:0]         mem_rd_data,
  output logic                  mem_wr_en,
  output logic [AW-1:0]         mem_wr_addr,
  output logic [EW-1:0]         mem_wr_data
`ifdef MAXHEAP_POP_STATS_EN
  ,
  output logic [31:0]           pop_total,
  output logic [CW:0]           sift_max
`endif
);

  // Two spare index bits keep 2i+2 from wrapping near capacity.
  localparam int IW = AW + 2;
  typedef logic [IW-1:0] idx_t;

  typedef struct packed {
    logic signed [PRIO_WIDTH-1:0] prio;
    logic signed [DATA_WIDTH-1:0] data;
  } entry_t;

  maxheap_pop_state_e state;
  logic [CW-1:0] n;
  idx_t   i;
  entry_t x;
  entry_t lchild;

  idx_t   n_ext, l_idx, r_idx, c_idx;
  entry_t rd, c;
  logic   left_ok, right_ok, right_wins, sink_down;

  assign rd      = entry_t'(mem_rd_data);
  assign n_ext   = idx_t'(n);
  assign l_idx   = idx_t'(heap_left(32'(i)));
  assign r_idx   = idx_t'(heap_right(32'(i)));
  assign left_ok  = l_idx < n_ext;
  assign right_ok = r_idx < n_ext;

  // In CMP the read port carries the right child; left wins ties, absent right never wins.
  assign right_wins = right_ok && (rd.prio > lchild.prio);
  assign c          = right_wins ? rd : lchild;
  assign c_idx      = right_wins ? r_idx : l_idx;
  assign sink_down  = c.prio > x.prio;

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    case (state)
      OFFER: mem_rd_addr = AW'(heap_count - CW'(1));
      RDL: begin
        if (left_ok) begin
          mem_rd_addr = AW'(l_idx);
        end else begin
          mem_wr_en   = 1'b1;
          mem_wr_addr = AW'(i);
          mem_wr_data = x;
        end
      end
      RDR: mem_rd_addr = right_ok ? AW'(r_idx) : '0;
      CMP: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = AW'(i);
        mem_wr_data = sink_down ? c : x;
      end
      default: ;
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge source_clk) begin
    if (reset) begin
      state        <= IDLE;
      source_valid <= 1'b0;
      source_data  <= '0;
      source_prio  <= '0;
      heap_dec     <= 1'b0;
      pop_busy     <= 1'b0;
      n            <= '0;
      i            <= '0;
      x            <= '0;
      lchild       <= '0;
    end else begin
      heap_dec <= 1'b0;
      case (state)
        IDLE: begin
          // heap_dec high means the inserter has not yet applied the last decrement.
          if (heap_count != '0 && !heap_dec) begin
            pop_busy <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          source_prio  <= rd.prio;
          source_data  <= rd.data;
          source_valid <= 1'b1;
          state        <= OFFER;
        end
        OFFER: begin
          if (source_ready) begin
            source_valid <= 1'b0;
            heap_dec     <= 1'b1;
            n            <= heap_count - CW'(1);
            if (heap_count == CW'(1)) begin
              pop_busy <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= LAST;
            end
          end
        end
        LAST: begin
          x     <= rd;
          i     <= '0;
          state <= RDL;
        end
        RDL: begin
          if (left_ok) begin
            state <= RDR;
          end else begin
            pop_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        RDR: begin
          lchild <= rd;
          state  <= CMP;
        end
        CMP: begin
          if (sink_down) begin
            i     <= c_idx;
            state <= RDL;
          end else begin
            pop_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAXHEAP_POP_STATS_EN
  logic [CW:0] depth;

  always_ff @(posedge source_clk) begin
    if (reset) begin
      pop_total <= '0;
      sift_max  <= '0;
      depth     <= '0;
    end else begin
      if (state == OFFER && source_ready && pop_total != '1) begin
        pop_total <= pop_total + 32'd1;
      end
      if (state == LAST) begin
        depth <= '0;
      end else if (state == CMP && sink_down) begin
        depth <= depth + 1'b1;
        if (depth + 1'b1 > sift_max) begin
          sift_max <= depth + 1'b1;
        end
      end
    end
  end
`endif

  heap_count_legal: assert property (@(posedge source_clk) disable iff (reset)
    heap_count <= CW'(TOT_SIZE));

endmodule

// File: tb/tb_maxheap_pop.sv
// Scoreboard bench for maxheap_pop: bench-side inserter/RAM model, directed preloads,
// expected outputs queued at load time and checked by an independent monitor.
module tb_maxheap_pop;

  localparam int DW = 10;
  localparam int PW = 32;
  localparam int TS = 4;
  localparam int AW = 2;
  localparam int CW = 3;
  localparam int EW = PW + DW;

  typedef struct {
    logic [PW-1:0] prio;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          source_valid;
  logic          source_ready = 1'b0;
  logic [DW-1:0] source_data;
  logic [PW-1:0] source_prio;
  logic [CW-1:0] heap_count;
  logic          heap_dec;
  logic          pop_busy;
  logic [AW-1:0] mem_rd_addr;
  logic [EW-1:0] mem_rd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [EW-1:0] mem_wr_data;
`ifdef MAXHEAP_POP_STATS_EN
  logic [31:0]   pop_total;
  logic [CW:0]   sift_max;
`endif

  maxheap_pop #(.DATA_WIDTH(DW), .PRIO_WIDTH(PW), .TOT_SIZE(TS)) dut (
    .source_clk   (clk),
    .reset        (reset),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_data  (source_data),
    .source_prio  (source_prio),
    .heap_count   (heap_count),
    .heap_dec     (heap_dec),
    .pop_busy     (pop_busy),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data)
`ifdef MAXHEAP_POP_STATS_EN
    ,
    .pop_total    (pop_total),
    .sift_max     (sift_max)
`endif
  );

  always #5 clk = ~clk;

  // Inserter stand-in and 1-cycle registered-read RAM.
  logic [EW-1:0] mem [TS];
  logic [EW-1:0] pre_mem [TS];
  logic          load_en = 1'b0;
  logic [CW-1:0] load_val = '0;

  always @(posedge clk) begin
    if (reset) begin
      heap_count <= '0;
    end else if (load_en) begin
      heap_count <= load_val;
    end else if (heap_dec) begin
      heap_count <= heap_count - 1'b1;
    end
    if (load_en) begin
      for (int k = 0; k < TS; k++) mem[k] <= pre_mem[k];
    end else if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
    mem_rd_data <= mem[mem_rd_addr];
  end

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts events and checks every handshake against the scoreboard.
  int dec_cnt = 0, wr_cnt = 0, act_cnt = 0, hs_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (heap_dec) dec_cnt++;
      if (mem_wr_en) wr_cnt++;
      if (source_valid || pop_busy || heap_dec || mem_wr_en) act_cnt++;
      if (source_valid && source_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got prio %0d data %0d, none expected",
                   $signed(source_prio), $signed(source_data));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_prio", 64'(source_prio), 64'(e.prio));
          check("out_data", 64'(source_data), 64'(e.data));
        end
      end
    end
  end

  function automatic logic [EW-1:0] mk(input int prio, input int data);
    logic [PW-1:0] p;
    logic [DW-1:0] d;
    p = PW'(prio);
    d = DW'(data);
    return {p, d};
  endfunction

  task automatic expect_out(input int prio, input int data);
    exp_t e;
    e.prio = PW'(prio);
    e.data = DW'(data);
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int cnt);
    load_val = CW'(cnt);
    load_en  = 1'b1;
    tick(1);
    load_en  = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int b;
    b = budget;
    while (!source_valid && b > 0) begin
      tick(1);
      b--;
    end
    if (!source_valid) check({name, "_valid_timeout"}, 64'(source_valid), 64'(1));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int b;
    b = budget;
    while ((heap_count != 0 || pop_busy || source_valid || heap_dec) && b > 0) begin
      tick(1);
      b--;
    end
    check({name, "_drained"}, 64'(pop_busy || source_valid || heap_count != 0), 64'(0));
  endtask

  int base_dec, base_wr, base_act, base_hs, bad;

  initial begin
    // Test 1: reset state and idle with empty heap.
    tick(3);
    reset = 1'b0;
    check("rst_valid", 64'(source_valid), 64'(0));
    check("rst_busy", 64'(pop_busy), 64'(0));
    check("rst_dec", 64'(heap_dec), 64'(0));
    check("rst_wr_en", 64'(mem_wr_en), 64'(0));
    check("rst_prio", 64'(source_prio), 64'(0));
    base_act = act_cnt;
    tick(100);
    check("idle_quiet", 64'(act_cnt - base_act), 64'(0));

    // Tests 2/3: {90,70,30,50}, held offer under backpressure, then drain in order.
    pre_mem[0] = mk(90, 1); pre_mem[1] = mk(70, 2);
    pre_mem[2] = mk(30, 3); pre_mem[3] = mk(50, 4);
    expect_out(90, 1); expect_out(70, 2); expect_out(50, 4); expect_out(30, 3);
    base_dec = dec_cnt; base_wr = wr_cnt; base_hs = hs_cnt;
    source_ready = 1'b0;
    load(4);
    wait_valid("bp", 20);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (!(source_valid && pop_busy && !mem_wr_en && source_prio == 32'd90)) bad++;
      tick(1);
    end
    check("bp_hold_cycles_bad", 64'(bad), 64'(0));
    check("bp_no_writes", 64'(wr_cnt - base_wr), 64'(0));
    check("bp_no_dec", 64'(dec_cnt - base_dec), 64'(0));
    source_ready = 1'b1;
    tick(1);
    source_ready = 1'b0;
    wait_valid("second", 30);
    check("single_hs", 64'(hs_cnt - base_hs), 64'(1));
    check("single_dec", 64'(dec_cnt - base_dec), 64'(1));
    check("first_sift_writes", 64'(wr_cnt - base_wr), 64'(2));
    check("ram0_prio", 64'(mem[0][EW-1:DW]), 64'(70));
    check("ram1_prio", 64'(mem[1][EW-1:DW]), 64'(50));
    check("ram2_prio", 64'(mem[2][EW-1:DW]), 64'(30));
    source_ready = 1'b1;
    wait_drain("t2", 200);
    check("t2_hs", 64'(hs_cnt - base_hs), 64'(4));
    check("t2_dec", 64'(dec_cnt - base_dec), 64'(4));
    check("t2_writes", 64'(wr_cnt - base_wr), 64'(5));
    check("t2_sb_empty", 64'(exp_q.size()), 64'(0));

    // Test 4: equal priorities; left-wins ties and strict sift give data order 11,14,12,13.
    pre_mem[0] = mk(70, 11); pre_mem[1] = mk(70, 12);
    pre_mem[2] = mk(40, 13); pre_mem[3] = mk(70, 14);
    expect_out(70, 11); expect_out(70, 14); expect_out(70, 12); expect_out(40, 13);
    base_hs = hs_cnt;
    load(4);
    wait_drain("t4", 200);
    check("t4_hs", 64'(hs_cnt - base_hs), 64'(4));
    check("t4_sb_empty", 64'(exp_q.size()), 64'(0));

    // Test 5: single negative-priority entry, no sift, immediate return to idle.
    pre_mem[0] = mk(-5, -3);
    expect_out(-5, -3);
    base_dec = dec_cnt; base_wr = wr_cnt;
    load(1);
    wait_valid("t5", 10);
    tick(1);
    check("t5_busy_dropped", 64'(pop_busy), 64'(0));
    check("t5_valid_dropped", 64'(source_valid), 64'(0));
    check("t5_dec_pulse", 64'(heap_dec), 64'(1));
    tick(4);
    check("t5_stays_idle", 64'(pop_busy), 64'(0));
    check("t5_dec_count", 64'(dec_cnt - base_dec), 64'(1));
    check("t5_no_writes", 64'(wr_cnt - base_wr), 64'(0));

    // Test 6: reset during the compare step of a 4-entry pop.
    pre_mem[0] = mk(90, 1); pre_mem[1] = mk(70, 2);
    pre_mem[2] = mk(30, 3); pre_mem[3] = mk(50, 4);
    expect_out(90, 1);
    load(4);
    wait_valid("t6", 10);
    tick(4);
    check("t6_in_cmp_write", 64'(mem_wr_en), 64'(1));
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    source_ready = 1'b0;
    check("t6_valid", 64'(source_valid), 64'(0));
    check("t6_busy", 64'(pop_busy), 64'(0));
    check("t6_dec", 64'(heap_dec), 64'(0));
    check("t6_wr_en", 64'(mem_wr_en), 64'(0));
    check("t6_wr_addr", 64'(mem_wr_addr), 64'(0));
    check("t6_wr_data", 64'(mem_wr_data), 64'(0));
    check("t6_rd_addr", 64'(mem_rd_addr), 64'(0));
    check("t6_prio", 64'(source_prio), 64'(0));
    check("t6_data", 64'(source_data), 64'(0));
    base_act = act_cnt;
    tick(10);
    check("t6_idle_after", 64'(act_cnt - base_act), 64'(0));
    check("t6_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
